// File: rtl/axi_sony_imx_pkg.sv
// axi_sony_imx_pkg: register map, CONTROL field positions and channel FSM encodings for the IMX control block.
package axi_sony_imx_pkg;
    localparam int NUM_CAMS        = 3;
    localparam int REG_CONTROL     = 0;
    localparam int REG_STATUS      = 1;
    localparam int REG_TRIG_LEN    = 2;
    localparam int REG_TRIG_PERIOD = 3;
    localparam int REG_ROWS        = 4;
    localparam int REG_ROW_WIDTH   = 7;
    localparam int REG_TAP         = 10;
    localparam int CTRL_POWER      = 0;
    localparam int CTRL_XCLEAR     = 4;
    localparam int CTRL_IO_RST     = 8;
    localparam int CTRL_TAP_RST    = 12;
    localparam int CTRL_TRIG_EN    = 16;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;
endpackage

// File: rtl/imx_sync_measure.sv
// imx_sync_measure: per-camera VS/HS synchroniser, frame geometry counters and registered LVDS data.
module imx_sync_measure #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          io_rst,
    input  logic [DW-1:0] raw_data,
    input  logic          vs,
    input  logic          hs,
    output logic [DW-1:0] sync_data,
    output logic          vs_sync,
    output logic          hs_sync,
    output logic [31:0]   rows,
    output logic [31:0]   row_width
);
    logic [1:0]  vs_ff, hs_ff;
    logic        vs_d, hs_d;
    logic [31:0] row_cnt, hs_cnt;
    logic        hs_rise, hs_fall, vs_fall;

    assign vs_sync = vs_ff[1];
    assign hs_sync = hs_ff[1];
    assign hs_rise = hs_sync & ~hs_d;
    assign hs_fall = ~hs_sync & hs_d;
    assign vs_fall = ~vs_sync & vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_ff <= '0;
            hs_ff <= '0;
            vs_d  <= 1'b0;
            hs_d  <= 1'b0;
        end else begin
            vs_ff <= {vs_ff[0], vs};
            hs_ff <= {hs_ff[0], hs};
            vs_d  <= vs_sync;
            hs_d  <= hs_sync;
        end
    end

    // Counters saturate rather than wrap so a stuck sync line reads as all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_data <= '0;
            row_cnt   <= '0;
            hs_cnt    <= '0;
            rows      <= '0;
            row_width <= '0;
        end else if (io_rst) begin
            sync_data <= '0;
            row_cnt   <= '0;
            hs_cnt    <= '0;
            rows      <= '0;
            row_width <= '0;
        end else begin
            sync_data <= raw_data;
            row_cnt   <= vs_fall ? '0 : (vs_sync && hs_rise && row_cnt != '1) ? row_cnt + 32'd1 : row_cnt;
            rows      <= vs_fall ? row_cnt : rows;
            hs_cnt    <= hs_fall ? '0 : (hs_sync && hs_cnt != '1) ? hs_cnt + 32'd1 : hs_cnt;
            row_width <= hs_fall ? hs_cnt : row_width;
        end
    end
endmodule

// File: rtl/axi_sony_imx_control.sv
// axi_sony_imx_control: AXI4-Lite control of power, reset, trigger and tap delay for three IMX sensors,
// with frame geometry measurement per camera.
module axi_sony_imx_control
    import axi_sony_imx_pkg::*;
#(
    parameter int ADDR_WIDTH             = 10,
    parameter int DATA_WIDTH             = 32,
    parameter int LANE_WIDTH             = 8,
    parameter int DEFAULT_TRIGGER_LEN    = 10,
    parameter int DEFAULT_TRIGGER_PERIOD = 100
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    input  logic                    i_awvalid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    output logic                    o_awready,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [1:0]              o_rresp,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_serdes_0_io_rst,
    input  logic [8*LANE_WIDTH-1:0] i_cam_0_raw_data,
    output logic [8*LANE_WIDTH-1:0] o_cam_0_sync_data,
    output logic [5*LANE_WIDTH-1:0] o_cam_0_tap_data,
    output logic                    o_cam_0_trigger,
    output logic                    o_cam_0_xclear_n,
    output logic                    o_cam_0_power_en,
    output logic                    o_cam_0_tap_delay_rst,
    input  logic                    i_cam_0_imx_vs,
    input  logic                    i_cam_0_imx_hs,
    output logic                    o_serdes_1_io_rst,
    input  logic [8*LANE_WIDTH-1:0] i_cam_1_raw_data,
    output logic [8*LANE_WIDTH-1:0] o_cam_1_sync_data,
    output logic [5*LANE_WIDTH-1:0] o_cam_1_tap_data,
    output logic                    o_cam_1_trigger,
    output logic                    o_cam_1_xclear_n,
    output logic                    o_cam_1_power_en,
    output logic                    o_cam_1_tap_delay_rst,
    input  logic                    i_cam_1_imx_vs,
    input  logic                    i_cam_1_imx_hs,
    output logic                    o_serdes_2_io_rst,
    input  logic [8*LANE_WIDTH-1:0] i_cam_2_raw_data,
    output logic [8*LANE_WIDTH-1:0] o_cam_2_sync_data,
    output logic [5*LANE_WIDTH-1:0] o_cam_2_tap_data,
    output logic                    o_cam_2_trigger,
    output logic                    o_cam_2_xclear_n,
    output logic                    o_cam_2_power_en,
    output logic                    o_cam_2_tap_delay_rst,
    input  logic                    i_cam_2_imx_vs,
    input  logic                    i_cam_2_imx_hs
);
    localparam int RW = 8*LANE_WIDTH;
    localparam int TW = 5*LANE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(REG_CONTROL);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(REG_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_LEN    = ADDR_WIDTH'(REG_TRIG_LEN);
    localparam logic [ADDR_WIDTH-1:0] A_PERIOD = ADDR_WIDTH'(REG_TRIG_PERIOD);

    wr_state_t             w_state, w_next;
    rd_state_t             r_state, r_next;
    logic                  wr_en, rd_en, wr_ctrl, wr_period, trig_en, trigger;
    logic [2:0]            power_en, xclear_n, io_rst, tap_pulse, vs_s, hs_s, vs_in, hs_in;
    logic [DATA_WIDTH-1:0] trig_len, trig_period, trig_cnt, cnt_inc, rd_val, ctrl_rd;
    logic [4:0]            tap       [NUM_CAMS];
    logic [31:0]           rows      [NUM_CAMS];
    logic [31:0]           row_width [NUM_CAMS];
    logic [RW-1:0]         raw       [NUM_CAMS];
    logic [RW-1:0]         sync_d    [NUM_CAMS];
    logic [TW-1:0]         tap_data  [NUM_CAMS];

    assign raw[0] = i_cam_0_raw_data;
    assign raw[1] = i_cam_1_raw_data;
    assign raw[2] = i_cam_2_raw_data;
    assign vs_in  = {i_cam_2_imx_vs, i_cam_1_imx_vs, i_cam_0_imx_vs};
    assign hs_in  = {i_cam_2_imx_hs, i_cam_1_imx_hs, i_cam_0_imx_hs};

    for (genvar n = 0; n < NUM_CAMS; n++) begin : g_cam
        imx_sync_measure #(.DW(RW)) u_meas (
            .clk       (i_axi_clk),
            .rst_n     (i_axi_rst),
            .io_rst    (io_rst[n]),
            .raw_data  (raw[n]),
            .vs        (vs_in[n]),
            .hs        (hs_in[n]),
            .sync_data (sync_d[n]),
            .vs_sync   (vs_s[n]),
            .hs_sync   (hs_s[n]),
            .rows      (rows[n]),
            .row_width (row_width[n])
        );
        assign tap_data[n] = {LANE_WIDTH{tap[n]}};
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE:  w_next = (i_awvalid && i_wvalid) ? W_ACK : W_IDLE;
            W_ACK:   w_next = W_RESP;
            W_RESP:  w_next = i_bready ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  r_next = i_arvalid ? R_ACK : R_IDLE;
            R_ACK:   r_next = R_DATA;
            R_DATA:  r_next = i_rready ? R_IDLE : R_DATA;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        o_awready = (w_state == W_ACK);
        o_wready  = (w_state == W_ACK);
        o_bvalid  = (w_state == W_RESP);
        o_bresp   = RESP_OKAY;
        o_arready = (r_state == R_ACK);
        o_rvalid  = (r_state == R_DATA);
        o_rresp   = RESP_OKAY;
    end

    assign wr_en     = (w_state == W_ACK);
    assign rd_en     = (r_state == R_ACK);
    assign wr_ctrl   = wr_en && i_awaddr == A_CTRL;
    assign wr_period = wr_en && i_awaddr == A_PERIOD;

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            power_en    <= '0;
            xclear_n    <= '0;
            io_rst      <= '1;
            trig_en     <= 1'b0;
            tap_pulse   <= '0;
            trig_len    <= DATA_WIDTH'(DEFAULT_TRIGGER_LEN);
            trig_period <= DATA_WIDTH'(DEFAULT_TRIGGER_PERIOD);
            for (int i = 0; i < NUM_CAMS; i++) tap[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                power_en <= i_wdata[CTRL_POWER +: 3];
                xclear_n <= i_wdata[CTRL_XCLEAR +: 3];
                io_rst   <= i_wdata[CTRL_IO_RST +: 3];
                trig_en  <= i_wdata[CTRL_TRIG_EN];
            end
            tap_pulse   <= wr_ctrl ? i_wdata[CTRL_TAP_RST +: 3] : '0;
            trig_len    <= (wr_en && i_awaddr == A_LEN) ? i_wdata : trig_len;
            trig_period <= wr_period ? i_wdata : trig_period;
            for (int i = 0; i < NUM_CAMS; i++)
                if (wr_en && i_awaddr == ADDR_WIDTH'(REG_TAP + i)) tap[i] <= i_wdata[4:0];
        end
    end

    // A period of 0 makes cnt_inc >= period always true, pinning the counter at 0.
    assign cnt_inc = trig_cnt + DATA_WIDTH'(1);
    assign trigger = trig_en && trig_period != '0 && trig_cnt < trig_len;

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) trig_cnt <= '0;
        else            trig_cnt <= (!trig_en || wr_period || cnt_inc >= trig_period) ? '0 : cnt_inc;
    end

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_POWER +: 3]  = power_en;
        ctrl_rd[CTRL_XCLEAR +: 3] = xclear_n;
        ctrl_rd[CTRL_IO_RST +: 3] = io_rst;
        ctrl_rd[CTRL_TRIG_EN]     = trig_en;
        rd_val = (i_araddr == A_CTRL)   ? ctrl_rd :
                 (i_araddr == A_STATUS) ? DATA_WIDTH'({hs_s, 1'b0, vs_s}) :
                 (i_araddr == A_LEN)    ? trig_len :
                 (i_araddr == A_PERIOD) ? trig_period : '0;
        for (int i = 0; i < NUM_CAMS; i++) begin
            if (i_araddr == ADDR_WIDTH'(REG_ROWS + i))      rd_val = DATA_WIDTH'(rows[i]);
            if (i_araddr == ADDR_WIDTH'(REG_ROW_WIDTH + i)) rd_val = DATA_WIDTH'(row_width[i]);
            if (i_araddr == ADDR_WIDTH'(REG_TAP + i))       rd_val = DATA_WIDTH'(tap[i]);
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) o_rdata <= '0;
        else if (rd_en) o_rdata <= rd_val;
    end

    assign o_serdes_0_io_rst     = io_rst[0];
    assign o_serdes_1_io_rst     = io_rst[1];
    assign o_serdes_2_io_rst     = io_rst[2];
    assign o_cam_0_sync_data     = sync_d[0];
    assign o_cam_1_sync_data     = sync_d[1];
    assign o_cam_2_sync_data     = sync_d[2];
    assign o_cam_0_tap_data      = tap_data[0];
    assign o_cam_1_tap_data      = tap_data[1];
    assign o_cam_2_tap_data      = tap_data[2];
    assign o_cam_0_trigger       = trigger;
    assign o_cam_1_trigger       = trigger;
    assign o_cam_2_trigger       = trigger;
    assign o_cam_0_xclear_n      = xclear_n[0];
    assign o_cam_1_xclear_n      = xclear_n[1];
    assign o_cam_2_xclear_n      = xclear_n[2];
    assign o_cam_0_power_en      = power_en[0];
    assign o_cam_1_power_en      = power_en[1];
    assign o_cam_2_power_en      = power_en[2];
    assign o_cam_0_tap_delay_rst = tap_pulse[0];
    assign o_cam_1_tap_delay_rst = tap_pulse[1];
    assign o_cam_2_tap_delay_rst = tap_pulse[2];
endmodule

// File: tb/tb_axi_sony_imx_control.sv
// tb_axi_sony_imx_control: directed AXI-Lite and camera-pin stimulus with a read-response scoreboard.
module tb_axi_sony_imx_control;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_awvalid = 0, i_wvalid = 0, i_bready = 1, i_arvalid = 0, rready = 1;
    logic [AW-1:0] i_awaddr = '0, i_araddr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]    o_bresp, o_rresp;
    logic [DW-1:0] o_rdata;
    logic [63:0]   raw0 = '0, raw1 = '0, raw2 = '0, sync0, sync1, sync2;
    logic [39:0]   tap0, tap1, tap2;
    logic          trig0, trig1, trig2, xclr0, xclr1, xclr2, pwr0, pwr1, pwr2;
    logic          tdr0, tdr1, tdr2, iorst0, iorst1, iorst2;
    logic          vs0 = 0, hs0 = 0, vs1 = 0, hs1 = 0, vs2 = 0, hs2 = 0;

    axi_sony_imx_control dut (
        .i_axi_clk(clk), .i_axi_rst(rst_n),
        .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .o_serdes_0_io_rst(iorst0), .i_cam_0_raw_data(raw0), .o_cam_0_sync_data(sync0),
        .o_cam_0_tap_data(tap0), .o_cam_0_trigger(trig0), .o_cam_0_xclear_n(xclr0),
        .o_cam_0_power_en(pwr0), .o_cam_0_tap_delay_rst(tdr0),
        .i_cam_0_imx_vs(vs0), .i_cam_0_imx_hs(hs0),
        .o_serdes_1_io_rst(iorst1), .i_cam_1_raw_data(raw1), .o_cam_1_sync_data(sync1),
        .o_cam_1_tap_data(tap1), .o_cam_1_trigger(trig1), .o_cam_1_xclear_n(xclr1),
        .o_cam_1_power_en(pwr1), .o_cam_1_tap_delay_rst(tdr1),
        .i_cam_1_imx_vs(vs1), .i_cam_1_imx_hs(hs1),
        .o_serdes_2_io_rst(iorst2), .i_cam_2_raw_data(raw2), .o_cam_2_sync_data(sync2),
        .o_cam_2_tap_data(tap2), .o_cam_2_trigger(trig2), .o_cam_2_xclear_n(xclr2),
        .o_cam_2_power_en(pwr2), .o_cam_2_tap_delay_rst(tdr2),
        .i_cam_2_imx_vs(vs2), .i_cam_2_imx_hs(hs2)
    );

    int          vectors = 0, miscompares = 0;
    int          tp0 = 0, tp1 = 0, tp2 = 0;
    string       exp_name [$];
    logic [33:0] exp_val  [$];
    string       cur_name;
    logic [33:0] cur_val;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout, expected handshake", nm);
    endtask

    // Read-response monitor: pops the oldest expectation on every completed R handshake.
    always @(negedge clk) begin
        if (o_rvalid && rready) begin
            if (exp_val.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got 0x%0h, expected no response", o_rdata);
            end else begin
                cur_name = exp_name.pop_front();
                cur_val  = exp_val.pop_front();
                chk(cur_name, {o_rresp, o_rdata}, cur_val);
            end
        end
    end

    always @(negedge clk) begin
        if (tdr0) tp0++;
        if (tdr1) tp1++;
        if (tdr2) tp2++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] want, input string nm, input int hold = 0);
        int n = 0;
        exp_name.push_back(nm);
        exp_val.push_back({2'b00, want});
        i_araddr  = a;
        i_arvalid = 1;
        while (!o_arready && n < 20) begin tick(); n++; end
        if (!o_arready) begin timeout({nm, "_arready"}); i_arvalid = 0; return; end
        tick();
        i_arvalid = 0;
        if (hold > 0) begin
            rready = 0;
            for (int i = 0; i < hold; i++) begin
                chk({nm, "_rvalid_held"}, o_rvalid, 1);
                chk({nm, "_rdata_held"}, o_rdata, want);
                tick();
            end
            rready = 1;
        end
        n = 0;
        while (o_rvalid && n < 20) begin tick(); n++; end
        if (o_rvalid) timeout({nm, "_rvalid_drop"});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input int bhold = 0);
        int n = 0;
        i_awaddr  = a;
        i_wdata   = d;
        i_awvalid = 1;
        i_wvalid  = 1;
        i_bready  = (bhold == 0);
        while (!(o_awready && o_wready) && n < 20) begin tick(); n++; end
        if (!(o_awready && o_wready)) begin
            timeout("aw_w_ready");
            i_awvalid = 0;
            i_wvalid  = 0;
            i_bready  = 1;
            return;
        end
        tick();
        i_awvalid = 0;
        i_wvalid  = 0;
        for (int i = 0; i < bhold; i++) begin
            chk("bvalid_held", o_bvalid, 1);
            tick();
        end
        i_bready = 1;
        if (!o_bvalid) begin timeout("bvalid"); return; end
        chk("bresp", o_bresp, 2'b00);
        tick();
        chk("bvalid_drop", o_bvalid, 0);
    endtask

    task automatic count_trig(input int cycles, input int want, input string nm);
        int c0 = 0, c1 = 0, c2 = 0;
        for (int i = 0; i < cycles; i++) begin
            c0 += int'(trig0);
            c1 += int'(trig1);
            c2 += int'(trig2);
            tick();
        end
        chk({nm, "_cam0"}, c0, want);
        chk({nm, "_cam1"}, c1, want);
        chk({nm, "_cam2"}, c2, want);
    endtask

    logic [7:0] lane_seq [4] = '{8'h7F, 8'h80, 8'h00, 8'h40};
    int p0, p1, p2;

    initial begin
        tick(3);
        rst_n = 1;
        tick();
        chk("rst_io_rst", {iorst2, iorst1, iorst0}, 3'b111);
        chk("rst_xclear_n", {xclr2, xclr1, xclr0}, 3'b000);
        chk("rst_power_en", {pwr2, pwr1, pwr0}, 3'b000);
        chk("rst_valids", {o_awready, o_wready, o_bvalid, o_arready, o_rvalid}, 5'b0);
        chk("rst_rdata", o_rdata, 0);
        rd(0, 32'h0000_0700, "ctrl_reset");
        rd(2, 32'd10, "len_reset");
        rd(3, 32'd100, "period_reset");

        raw0 = 64'hABAB_ABAB_ABAB_ABAB;
        tick(2);
        chk("sync0_in_io_rst", sync0, 0);

        wr(0, 32'h0001_0077, 3);
        chk("power_en_on", {pwr2, pwr1, pwr0}, 3'b111);
        chk("xclear_n_on", {xclr2, xclr1, xclr0}, 3'b111);
        chk("io_rst_off", {iorst2, iorst1, iorst0}, 3'b000);
        count_trig(100, 10, "trig_10_of_100");

        wr(3, 32'd0);
        count_trig(20, 0, "trig_period0");
        wr(2, 32'd3);
        wr(3, 32'd8);
        count_trig(80, 30, "trig_3_of_8");
        wr(2, 32'd20);
        count_trig(40, 40, "trig_len_ge_period");

        wr(11, 32'h15);
        chk("tap1_lanes", tap1, 40'hAD6B5AD6B5);
        chk("tap0_untouched", tap0, 0);
        chk("tap2_untouched", tap2, 0);
        rd(11, 32'h15, "tap1_readback");

        p0 = tp0; p1 = tp1; p2 = tp2;
        wr(0, 32'h0001_2077);
        tick(3);
        chk("tap_rst1_pulses", tp1 - p1, 1);
        chk("tap_rst0_pulses", tp0 - p0, 0);
        chk("tap_rst2_pulses", tp2 - p2, 0);
        rd(0, 32'h0001_0077, "ctrl_tap_selfclear");

        for (int i = 0; i < 4; i++) begin
            raw0 = {56'h0, lane_seq[i]};
            if (i > 0) chk("sync0_lane0", sync0[7:0], lane_seq[i-1]);
            tick();
        end
        chk("sync0_lane0_last", sync0[7:0], 8'h40);

        vs0 = 1;
        tick(5);
        rd(1, 32'h1, "status_vs0");
        for (int r = 0; r < 10; r++) begin
            hs0 = 1;
            tick(100);
            hs0 = 0;
            tick(20);
        end
        vs0 = 0;
        tick(10);
        rd(4, 32'd10, "rows_0");
        rd(7, 32'd100, "row_width_0");
        rd(5, 32'd0, "rows_1_idle");

        rd(10'h3FF, 32'd0, "unmapped_read");
        wr(10'h3FE, 32'hFFFF_FFFF);
        rd(0, 32'h0001_0077, "ctrl_after_unmapped_wr");
        rd(2, 32'd20, "len_rready_hold", 5);

        for (int i = 0; i < 50 && exp_val.size() != 0; i++) tick();
        if (exp_val.size() != 0) timeout("scoreboard_drain");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_sony_imx_control.md
Name: axi_sony_imx_control

Overview:
- AXI4-Lite slave control block for three Sony IMX image sensors, all in one clock domain.
- Drives the camera power enable, XCLEAR_N, trigger, SERDES I/O reset and tap-delay controls.
- Registers the raw LVDS deserialised data into a synchronised output.
- Measures VSYNC/HSYNC frame geometry and exposes the counts for software readback.

Parameters:
- ADDR_WIDTH, 10: AXI address width; address is a word index.
- DATA_WIDTH, 32: AXI data width.
- LANE_WIDTH, 8: data lanes per camera (8 bits each, 5-bit tap per lane).
- DEFAULT_TRIGGER_LEN, 10: reset value of trigger pulse width, in clocks.
- DEFAULT_TRIGGER_PERIOD, 100: reset value of trigger period, in clocks.

Ports:
- i_axi_clk  in  1  single clock for all logic.
- i_axi_rst  in  1  asynchronous, active-low reset.
- AXI write: i_awvalid in 1; i_awaddr in ADDR_WIDTH; o_awready out 1; i_wvalid in 1; o_wready out 1; i_wdata in DATA_WIDTH; o_bvalid out 1; i_bready in 1; o_bresp out 2.
- AXI read: i_arvalid in 1; o_arready out 1; i_araddr in ADDR_WIDTH; o_rvalid out 1; i_rready in 1; o_rresp out 2; o_rdata out DATA_WIDTH.
- Per camera n=0..2:
  - o_serdes_n_io_rst out 1
  - i_cam_n_raw_data in 8*LANE_WIDTH
  - o_cam_n_sync_data out 8*LANE_WIDTH
  - o_cam_n_tap_data out 5*LANE_WIDTH
  - o_cam_n_trigger out 1
  - o_cam_n_xclear_n out 1
  - o_cam_n_power_en out 1
  - o_cam_n_tap_delay_rst out 1
  - i_cam_n_imx_vs in 1
  - i_cam_n_imx_hs in 1

Behaviour:
- Reset values (all outputs low unless listed):
  - o_serdes_n_io_rst=1; o_cam_n_xclear_n=0.
  - All ready/valid outputs 0; bresp=rresp=0; rdata=0.
  - Trigger registers hold their defaults.
- Write channel:
  - Idle until i_awvalid & i_wvalid are both high.
  - Then o_awready and o_wready pulse together for one cycle and the register is updated.
  - o_bvalid=1 (bresp=00) from the next cycle until i_bready is sampled high.
  - No new write is accepted while bvalid is high.
  - Full-word writes only (no strobes).
- Read channel:
  - When i_arvalid is high and no read is pending, o_arready pulses for one cycle.
  - Next cycle o_rvalid=1 with o_rdata and rresp=00; data is held stable until i_rready.
  - Reads and writes proceed independently.
- Unmapped addresses read 0; writes to them are ignored; the response is still OKAY.
- Register map (word index):
  - 0 CONTROL rw:
    - [2:0] power_en, reset 0
    - [6:4] xclear_n, reset 0
    - [10:8] serdes_io_rst, reset 111
    - [14:12] tap_delay_rst, write-1 pulse, self-clears, reads 0
    - [16] trigger_en, reset 0
  - 1 STATUS ro: [2:0] vs, [6:4] hs (2-flop synchronised).
  - 2 TRIGGER_LEN rw.
  - 3 TRIGGER_PERIOD rw.
  - 4..6 ROWS_n ro: HSYNC rising edges counted while VS is high; latched on VS falling edge.
  - 7..9 ROW_WIDTH_n ro: clocks HS was high; latched on HS falling edge.
  - 10..12 TAP_n rw [4:0]: replicated into every 5-bit lane slice of o_cam_n_tap_data.
- tap_delay_rst:
  - Exactly one-cycle pulse on o_cam_n_tap_delay_rst, in the cycle after the write handshake.
- Trigger generator:
  - A shared counter runs 0..PERIOD-1 while trigger_en=1.
  - All three o_cam_n_trigger = (count < LEN) & trigger_en.
  - When trigger_en=0, the counter is held at 0.
  - PERIOD=0 forces trigger low.
  - LEN>=PERIOD gives a constant high.
  - Writing PERIOD restarts the counter at 0.
- Sync data:
  - o_cam_n_sync_data = i_cam_n_raw_data delayed one clock.
  - Held at 0 while that camera's serdes_io_rst=1.
- Frame measurement:
  - Counters are 32-bit saturating and cleared while serdes_io_rst[n]=1.
  - Measurement uses the synchronised vs/hs (2-cycle input latency).
- Reset mid-transaction aborts it: valid outputs drop to 0.

Decomposition:
- Package axi_sony_imx_pkg: register index constants, CONTROL bit positions, OKAY response code.
- One natural sub-module, imx_sync_measure (one instance per camera):
  - VS/HS synchroniser
  - edge detect
  - row/width counters
  - sync-data register

Test Plan:
- After reset, read CONTROL -> 0x00000700; TRIGGER_LEN -> 10; TRIGGER_PERIOD -> 100; all o_serdes_n_io_rst=1, xclear_n=0.
- Write CONTROL=0x00010077 -> power_en=111, xclear_n=111, serdes rst=0, trigger_en=1.
  - Each o_cam_n_trigger is high for 10 of every 100 clocks.
  - bvalid is held until bready.
- Write TAP_1=0x15 -> o_cam_1_tap_data=0x15 in all 8 lane slices; read back 0x15; cameras 0 and 2 unaffected.
- Write CONTROL bit13 -> o_cam_1_tap_delay_rst pulses exactly 1 cycle; CONTROL readback has bit13=0.
- Drive camera 0 with VS high for 10 rows, each HS high 100 clocks, then VS low; serdes rst=0 -> ROWS_0=10, ROW_WIDTH_0=100.
- Drive raw lane0 sequence 7F,80,00,40 -> o_cam_0_sync_data lane0 shows the same sequence one clock later.
- Read index 0x3FF -> rdata 0, rresp 00.
- Hold rready low 5 cycles -> rvalid and rdata stay stable.
